sstv_line_sampler: RTL and testbench

Downstream consumer of the frequency-to-color mapper. It watches the same 12-bit frequency stream for the 1200 Hz horizontal sync, then times out the porch and samples the 2-bit pixel color once per pixel period. It packs four pixels per byte into a 2-entry output FIFO with a valid/ready handshake toward the frame-buffer writer.

---
 rtl/sstv_line_sampler.sv | 241 ++++++++++++++++++++++++
 tb/tb_sstv_line_sampler.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sstv_line_sampler.sv
// sstv_line_sampler
// Watches the tone-frequency stream for the horizontal sync tone, times out
// the porch, samples one 2-bit color per pixel period and packs four pixels
// per byte into a 2-entry FIFO with a valid/ready interface.

module sstv_line_sampler #(
  parameter logic [11:0] SYNC_LO         = 12'd1100,
  parameter logic [11:0] SYNC_HI         = 12'd1300,
  parameter int          SYNC_MIN_CYC    = 4000,
  parameter int          PORCH_CYC       = 572,
  parameter int          PIXEL_CYC       = 457,
  parameter int          PIXELS_PER_LINE = 320
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] freq,
  input  logic [1:0]  color,
  output logic [7:0]  pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        line_start,
  output logic        line_done,
  output logic        line_abort,
  output logic        overflow
);

  localparam int SRW     = $clog2(SYNC_MIN_CYC + 1);
  localparam int CNT_MAX = (PORCH_CYC > PIXEL_CYC) ? PORCH_CYC : PIXEL_CYC;
  localparam int CW      = $clog2(CNT_MAX);
  localparam int PCW     = $clog2(PIXELS_PER_LINE + 1);

  localparam logic [SRW-1:0] SYNC_FULL  = SRW'(SYNC_MIN_CYC);
  localparam logic [CW-1:0]  PORCH_LAST = CW'(PORCH_CYC - 1);
  localparam logic [CW-1:0]  PIX_LAST   = CW'(PIXEL_CYC - 1);
  localparam logic [CW-1:0]  PIX_MID    = CW'(PIXEL_CYC / 2);
  localparam logic [PCW-1:0] PIX_TOTAL  = PCW'(PIXELS_PER_LINE);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_SYNC,
    ST_PORCH,
    ST_ACTIVE
  } state_t;

  state_t         r_state;
  state_t         w_stateNext;

  logic [SRW-1:0] r_syncRun;
  logic [SRW-1:0] w_syncRunNext;
  logic           w_inSync;
  logic           w_syncQual;

  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_cntNext;
  logic [PCW-1:0] r_pixCount;
  logic [PCW-1:0] w_pixCountNext;
  logic [5:0]     r_packer;
  logic [5:0]     w_packerNext;

  logic           r_pushReq;
  logic           w_pushReqNext;
  logic           r_pushLast;
  logic           w_pushLastNext;
  logic [7:0]     r_pushData;
  logic [7:0]     w_pushDataNext;

  logic           r_lineStart;
  logic           w_lineStartNext;
  logic           r_lineAbort;
  logic           w_lineAbortNext;
  logic           r_lineDone;
  logic           r_overflow;

  logic [7:0]     r_mem [0:1];
  logic           r_wrPtr;
  logic           r_rdPtr;
  logic [1:0]     r_count;
  logic           w_fifoFull;
  logic           w_pop;
  logic           w_pushOk;
  logic           w_drop;

  // Sync detection: a run of in-window samples qualifies once it reaches the
  // minimum length; the look-ahead value lets the FSM react on that very edge.
  assign w_inSync      = (freq >= SYNC_LO) && (freq <= SYNC_HI);
  assign w_syncRunNext = !w_inSync ? '0 :
                         ((r_syncRun == SYNC_FULL) ? r_syncRun : r_syncRun + 1'b1);
  assign w_syncQual    = (w_syncRunNext == SYNC_FULL);

  // Saturating run-length of consecutive in-window frequency samples
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_syncRun <= '0;
    end else begin
      r_syncRun <= w_syncRunNext;
    end
  end

  // Next-state logic: line timing, pixel sampling and byte packing
  always_comb begin
    w_stateNext     = r_state;
    w_cntNext       = r_cnt;
    w_pixCountNext  = r_pixCount;
    w_packerNext    = r_packer;
    w_pushReqNext   = 1'b0;
    w_pushLastNext  = 1'b0;
    w_pushDataNext  = r_pushData;
    w_lineStartNext = 1'b0;
    w_lineAbortNext = 1'b0;

    case (r_state)
      ST_HUNT: begin
        if (w_syncQual) begin
          w_stateNext = ST_SYNC;
        end
      end

      ST_SYNC: begin
        if (!w_inSync) begin
          w_stateNext = ST_PORCH;
          w_cntNext   = '0;
        end
      end

      ST_PORCH: begin
        if (w_syncQual) begin
          w_stateNext = ST_SYNC;
        end else if (r_cnt == PORCH_LAST) begin
          w_stateNext     = ST_ACTIVE;
          w_cntNext       = '0;
          w_pixCountNext  = '0;
          w_packerNext    = '0;
          w_lineStartNext = 1'b1;
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end

      ST_ACTIVE: begin
        if (w_syncQual) begin
          // A new sync cuts the line short; bytes already queued are kept.
          w_stateNext     = ST_SYNC;
          w_cntNext       = '0;
          w_pixCountNext  = '0;
          w_packerNext    = '0;
          w_lineAbortNext = 1'b1;
        end else begin
          w_cntNext = (r_cnt == PIX_LAST) ? '0 : r_cnt + 1'b1;
          if (r_cnt == PIX_MID) begin
            w_pixCountNext = r_pixCount + 1'b1;
            w_packerNext   = {r_packer[3:0], color};
            if (r_pixCount[1:0] == 2'b11) begin
              // Fourth pixel of the byte: hand it to the FIFO on the next edge.
              w_pushReqNext  = 1'b1;
              w_pushDataNext = {r_packer, color};
              w_packerNext   = '0;
              if ((r_pixCount + 1'b1) == PIX_TOTAL) begin
                w_pushLastNext = 1'b1;
                w_stateNext    = ST_HUNT;
              end
            end
          end
        end
      end

      default: begin
        w_stateNext = ST_HUNT;
      end
    endcase
  end

  // State, counters, packer, push staging and start/abort pulse registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_HUNT;
      r_cnt       <= '0;
      r_pixCount  <= '0;
      r_packer    <= '0;
      r_pushReq   <= 1'b0;
      r_pushLast  <= 1'b0;
      r_pushData  <= '0;
      r_lineStart <= 1'b0;
      r_lineAbort <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_cnt       <= w_cntNext;
      r_pixCount  <= w_pixCountNext;
      r_packer    <= w_packerNext;
      r_pushReq   <= w_pushReqNext;
      r_pushLast  <= w_pushLastNext;
      r_pushData  <= w_pushDataNext;
      r_lineStart <= w_lineStartNext;
      r_lineAbort <= w_lineAbortNext;
    end
  end

  // A pop frees the head slot in the same edge, so a full FIFO can still
  // accept a byte when the consumer is draining it.
  assign w_fifoFull = (r_count == 2'd2);
  assign w_pop      = pix_valid && pix_ready;
  assign w_pushOk   = r_pushReq && (!w_fifoFull || w_pop);
  assign w_drop     = r_pushReq && w_fifoFull && !w_pop;

  // Two-entry output FIFO, sticky overflow flag and end-of-line pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
      r_wrPtr    <= 1'b0;
      r_rdPtr    <= 1'b0;
      r_count    <= 2'd0;
      r_overflow <= 1'b0;
      r_lineDone <= 1'b0;
    end else begin
      if (w_pushOk) begin
        r_mem[r_wrPtr] <= r_pushData;
        r_wrPtr        <= ~r_wrPtr;
      end
      if (w_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      case ({w_pushOk, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      r_lineDone <= r_pushReq && r_pushLast;
    end
  end

  assign pix_valid  = (r_count != 2'd0);
  assign pix_data   = pix_valid ? r_mem[r_rdPtr] : 8'h00;
  assign line_start = r_lineStart;
  assign line_done  = r_lineDone;
  assign line_abort = r_lineAbort;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_sstv_line_sampler.sv
// tb_sstv_line_sampler
// Directed line scenarios against a timestamp-based model of the line
// timing and a queue-based model of the output FIFO.

module tb_sstv_line_sampler;

  localparam int MIN_CYC = 8;
  localparam int PORCH   = 4;
  localparam int PIX     = 4;
  localparam int NPIX    = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] freq;
  logic [1:0]  color;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        line_start;
  logic        line_done;
  logic        line_abort;
  logic        overflow;

  sstv_line_sampler #(
    .SYNC_LO        (12'd1100),
    .SYNC_HI        (12'd1300),
    .SYNC_MIN_CYC   (MIN_CYC),
    .PORCH_CYC      (PORCH),
    .PIXEL_CYC      (PIX),
    .PIXELS_PER_LINE(NPIX)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .freq      (freq),
    .color     (color),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .line_start(line_start),
    .line_done (line_done),
    .line_abort(line_abort),
    .overflow  (overflow)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;

  // Model: sync run length, edge timestamps, captured pixels, FIFO queue
  int         mSyncRun;
  int         mEdge;
  int         mOrigin;
  bit         mHeld;
  int         mPixels[$];
  logic [7:0] mQ[$];
  bit         mPend;
  bit         mPendLast;
  int         mPendByte;
  bit         mStart;
  bit         mDone;
  bit         mAbort;
  bit         mOvf;

  // Observations of the DUT, indexed by the call number within a line
  int         evStart;
  int         evDone;
  int         evAbort;
  int         evOvf;
  int         evValid;
  logic [7:0] obsBytes[$];

  int colorSeq [0:7] = '{3, 2, 1, 0, 0, 1, 2, 3};

  task automatic checkVal(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic int byteAt(input int i);
    if (obsBytes.size() > i) return int'(obsBytes[i]);
    return -1;
  endfunction

  task automatic modelReset();
    mSyncRun  = 0;
    mEdge     = 0;
    mOrigin   = -1;
    mHeld     = 0;
    mPixels.delete();
    mQ.delete();
    mPend     = 0;
    mPendLast = 0;
    mPendByte = 0;
    mStart    = 0;
    mDone     = 0;
    mAbort    = 0;
    mOvf      = 0;
  endtask

  // One clock edge of the model. Line timing is measured from the edge at
  // which the sync tone ended: the porch spans the next PORCH edges and each
  // pixel k samples at PORCH + 1 + k*PIX + PIX/2 edges after that point.
  task automatic modelStep(input int f, input int c, input bit r);
    bit doPop;
    bit doPush;
    bit lastPush;
    bit inSync;
    int rel;
    int age;
    int s;
    mEdge++;
    doPop    = (mQ.size() != 0) && r;
    doPush   = mPend;
    lastPush = mPendLast;
    if (doPop) void'(mQ.pop_front());
    if (doPush) begin
      if (mQ.size() < 2) mQ.push_back(8'(mPendByte));
      else mOvf = 1;
    end
    mDone     = doPush && lastPush;
    mStart    = 0;
    mAbort    = 0;
    mPend     = 0;
    mPendLast = 0;

    inSync   = (f >= 1100) && (f <= 1300);
    mSyncRun = inSync ? ((mSyncRun < MIN_CYC) ? mSyncRun + 1 : MIN_CYC) : 0;

    if (mHeld) begin
      if (!inSync) begin
        mHeld   = 0;
        mOrigin = mEdge;
      end
    end else if (mSyncRun == MIN_CYC) begin
      if (mOrigin >= 0 && (mEdge - mOrigin) > PORCH) mAbort = 1;
      mHeld   = 1;
      mOrigin = -1;
      mPixels.delete();
    end else if (mOrigin >= 0) begin
      rel = mEdge - mOrigin;
      if (rel == PORCH) begin
        mStart = 1;
        mPixels.delete();
      end else if (rel > PORCH) begin
        age = rel - PORCH - 1;
        if (age % PIX == PIX / 2) begin
          mPixels.push_back(c);
          s = mPixels.size();
          if (s % 4 == 0) begin
            mPend     = 1;
            mPendByte = mPixels[s-4] * 64 + mPixels[s-3] * 16 + mPixels[s-2] * 4 + mPixels[s-1];
            mPendLast = (s == NPIX);
            if (s == NPIX) mOrigin = -1;
          end
        end
      end
    end
  endtask

  task automatic checkOutput();
    checkVal("pix_valid",  int'(pix_valid),  (mQ.size() != 0) ? 1 : 0);
    checkVal("pix_data",   int'(pix_data),   (mQ.size() != 0) ? int'(mQ[0]) : 0);
    checkVal("line_start", int'(line_start), int'(mStart));
    checkVal("line_done",  int'(line_done),  int'(mDone));
    checkVal("line_abort", int'(line_abort), int'(mAbort));
    checkVal("overflow",   int'(overflow),   int'(mOvf));
  endtask

  task automatic clearEvents();
    evStart = -1;
    evDone  = -1;
    evAbort = -1;
    evOvf   = -1;
    evValid = -1;
  endtask

  // Drive one cycle from a falling edge, step the model on the rising edge,
  // then compare on the next falling edge.
  task automatic applyStimulus(input int f, input int c, input bit r, input int n);
    freq      = 12'(f);
    color     = 2'(c);
    pix_ready = r;
    if (pix_valid && r) obsBytes.push_back(pix_data);
    @(posedge clk);
    modelStep(f, c, r);
    @(negedge clk);
    checkOutput();
    if (line_start && evStart < 0) evStart = n;
    if (line_done  && evDone  < 0) evDone  = n;
    if (line_abort && evAbort < 0) evAbort = n;
    if (overflow   && evOvf   < 0) evOvf   = n;
    if (pix_valid  && evValid < 0) evValid = n;
  endtask

  // Standard line: calls 1..10 sync tone, 11..15 porch, 16..47 eight pixels
  // of four cycles each, 48..51 idle. syncAt>0 inserts eight sync cycles.
  task automatic runLine(input int first, input int last, input bit rdyDef,
                         input int flip, input int syncAt);
    for (int n = first; n <= last; n++) begin
      int f;
      int c;
      bit r;
      f = (n <= 10) ? 1200 : 1500;
      if (syncAt > 0 && n >= syncAt && n < syncAt + 8) f = 1200;
      c = (n >= 16 && n <= 47) ? colorSeq[(n - 16) / 4] : 0;
      r = rdyDef ^ (n == flip);
      applyStimulus(f, c, r, n);
    end
  endtask

  task automatic asyncReset();
    #2 reset_n = 1'b0;
    #1 modelReset();
    checkVal("rst_pix_valid", int'(pix_valid), 0);
    checkVal("rst_pix_data",  int'(pix_data),  0);
    checkVal("rst_overflow",  int'(overflow),  0);
    checkOutput();
    @(negedge clk);
    checkOutput();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b0;
    freq      = 12'd0;
    color     = 2'd0;
    pix_ready = 1'b0;
    modelReset();
    @(negedge clk);
    checkVal("reset_valid", int'(pix_valid), 0);
    checkOutput();
    @(negedge clk);
    reset_n = 1'b1;

    // Scenario 1: full line, consumer always ready
    clearEvents();
    obsBytes.delete();
    runLine(1, 51, 1'b1, 0, 0);
    checkVal("s1_start_call", evStart, 15);
    checkVal("s1_valid_call", evValid, 31);
    checkVal("s1_done_call",  evDone,  47);
    checkVal("s1_no_abort",   evAbort, -1);
    checkVal("s1_nbytes",     obsBytes.size(), 2);
    checkVal("s1_byte0",      byteAt(0), 8'hE4);
    checkVal("s1_byte1",      byteAt(1), 8'h1B);

    // Scenario 2: sync tone one cycle too short
    clearEvents();
    for (int n = 1; n <= 27; n++) applyStimulus((n <= 7) ? 1200 : 1500, 0, 1'b1, n);
    checkVal("s2_no_start", evStart, -1);
    checkVal("s2_no_valid", evValid, -1);

    // Scenario 3: consumer stalled, then a second line overflows
    asyncReset();
    clearEvents();
    obsBytes.delete();
    runLine(1, 51, 1'b0, 0, 0);
    checkVal("s3_valid",    int'(pix_valid), 1);
    checkVal("s3_hold",     int'(pix_data),  8'hE4);
    checkVal("s3_no_ovf",   int'(overflow),  0);
    checkVal("s3_done",     evDone, 47);
    clearEvents();
    runLine(1, 51, 1'b0, 0, 0);
    checkVal("s3_ovf_call", evOvf, 31);
    checkVal("s3_ovf_held", int'(overflow), 1);
    checkVal("s3_hold2",    int'(pix_data), 8'hE4);
    asyncReset();

    // Scenario 4: sync arrives during pixel 6 and aborts the line
    clearEvents();
    obsBytes.delete();
    runLine(1, 43, 1'b1, 0, 36);
    checkVal("s4_abort_call", evAbort, 43);
    checkVal("s4_no_done",    evDone, -1);
    checkVal("s4_nbytes",     obsBytes.size(), 1);
    checkVal("s4_byte0",      byteAt(0), 8'hE4);
    clearEvents();
    runLine(11, 51, 1'b1, 0, 0);
    checkVal("s4_restart",    evStart, 15);
    checkVal("s4_done",       evDone, 47);
    checkVal("s4_nbytes2",    obsBytes.size(), 3);
    checkVal("s4_byte1",      byteAt(1), 8'hE4);
    checkVal("s4_byte2",      byteAt(2), 8'h1B);

    // Scenario 5: reset mid-line with one byte queued
    asyncReset();
    clearEvents();
    obsBytes.delete();
    runLine(1, 33, 1'b0, 0, 0);
    checkVal("s5_queued", int'(pix_valid), 1);
    checkVal("s5_data",   int'(pix_data),  8'hE4);
    asyncReset();
    clearEvents();
    for (int n = 1; n <= 20; n++) applyStimulus((n <= 7) ? 1200 : 1500, 3, 1'b1, n);
    checkVal("s5_hunt_start", evStart, -1);
    checkVal("s5_hunt_valid", evValid, -1);

    // Scenario 6: push and pop on the same edge while full
    asyncReset();
    clearEvents();
    obsBytes.delete();
    runLine(1, 51, 1'b0, 0, 0);
    clearEvents();
    runLine(1, 31, 1'b0, 31, 0);
    checkVal("s6_valid",  int'(pix_valid), 1);
    checkVal("s6_head",   int'(pix_data),  8'h1B);
    checkVal("s6_no_ovf", int'(overflow),  0);
    checkVal("s6_popped", byteAt(0), 8'hE4);
    runLine(32, 51, 1'b1, 0, 0);
    checkVal("s6_nbytes", obsBytes.size(), 4);
    checkVal("s6_byte1",  byteAt(1), 8'h1B);
    checkVal("s6_byte2",  byteAt(2), 8'hE4);
    checkVal("s6_byte3",  byteAt(3), 8'h1B);
    checkVal("s6_ovf_end", int'(overflow), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
